sr_frame_loader: RTL
====================

// Module: sr_frame_loader
// PURPOSE
//  Upstream feeder for the shift-register control stage. Accepts a configuration frame as a stream
//  of WORD_WIDTH-bit words over a valid/ready handshake and assembles it into one DATA_WIDTH-bit
//  word on din. It then pulses start to the shift-register control stage and holds din stable for
//  the whole shift. After a fixed wait it reports completion and accepts the next frame.
// PARAMETERS
//  DATA_WIDTH  170             width of assembled frame (matches downstream din)
//  WORD_WIDTH  32              width of one input word
//  CNT_WIDTH   8               width of wait counter; must hold DONE_WAIT
//  DONE_WAIT   DATA_WIDTH+4    cycles from start pulse to done pulse (downstream shift+load+idle)
// PORTS
//  clk        in   1           control clock, same clock as the shift-register control stage
//  rst_n      in   1           reset, asynchronous, active-low
//  wr_data    in   WORD_WIDTH  frame word
//  wr_valid   in   1           wr_data valid
//  wr_last    in   1           qualifies final word of frame (sampled with wr_valid)
//  wr_ready   out  1           word accepted on any edge where wr_valid & wr_ready
//  clear      in   1           synchronous abort of a partially received frame
//  din        out  DATA_WIDTH  assembled frame to downstream
//  start      out  1           one-cycle start pulse to downstream
//  busy       out  1           high from start cycle through done cycle
//  done       out  1           one-cycle completion pulse
//  frame_err  out  1           one-cycle pulse: framing error, frame discarded
//  word_cnt   out  3           words accepted in current frame (0..NWORDS-1)
// BEHAVIOUR
//  - NWORDS = ceil(DATA_WIDTH/WORD_WIDTH) = 6 at defaults. Word k is written to
//    din[k*WORD_WIDTH +: WORD_WIDTH]. The last word contributes only its low
//    DATA_WIDTH-(NWORDS-1)*WORD_WIDTH bits (10 at defaults); its upper bits are dropped.
//  - Reset (rst_n=0, async): state=FILL, din=0, word_cnt=0, wr_ready=1, and start, busy, done,
//    frame_err all 0.
//  - States: FILL, START, WAIT, DONE (one-hot).
//    FILL:  wr_ready=1. Each accepted word writes its slice and word_cnt++.
//      Case word_cnt==NWORDS-1 and wr_last=1 -> START.
//      Case word_cnt==NWORDS-1 and wr_last=0 -> frame_err pulse, word_cnt=0, stay in FILL.
//      Case word_cnt<NWORDS-1 and wr_last=1 -> frame_err pulse, word_cnt=0, stay in FILL.
//      On any error din keeps its partial contents; later words overwrite them.
//    START: start=1, busy=1, wr_ready=0; load wait counter with DONE_WAIT-1 -> WAIT.
//    WAIT:  busy=1, wr_ready=0; counter decrements each cycle; at counter==0 -> DONE.
//    DONE:  done=1, busy=1, wr_ready=0, word_cnt=0 -> FILL.
//  - Timing: final word accepted at edge E. start is high in the cycle after E (cycle T). done is
//    high in cycle T+DONE_WAIT. wr_ready returns high in cycle T+DONE_WAIT+1.
//  - din is registered. It changes only on accepted words in FILL and is constant from START
//    through DONE.
//  - clear in FILL: word_cnt=0. A word presented in the same cycle is consumed and discarded,
//    with no frame_err. clear has priority over wr_last. clear in START/WAIT/DONE is ignored,
//    because a shift in progress is never aborted.
//  - wr_valid with wr_ready=0 is not a handshake: the word is held by the source, and wr_last is
//    not evaluated.
//  - Reset mid-shift clears din and start immediately. The downstream stage must be reset
//    together with this block.
//  - Wait counter width: CNT_WIDTH bits. DONE_WAIT <= 2**CNT_WIDTH-1 is a legal-parameter
//    constraint, checked by an elaboration-time assertion.
// STRUCTURE
//  - Shared include sr_defs.vh holds: state one-hot localparams (FILL/START/WAIT/DONE); an NWORDS
//    ceil-div function; the last-word valid-bit-count constant.
//  - Single flat module; no sub-module is warranted. Assembly and countdown are inline.
// TESTING
//  1. Reset, 6 words 0x1..0x6 with wr_last on the 6th -> din[31:0]=0x1, din[169:160]=0x006,
//     start pulse 1 cycle after the 6th accept, done exactly 174 cycles after start.
//  2. 6th word 0xFFFFFFFF -> only din[169:160]=0x3FF is set; no bit beyond 169 exists or changes.
//  3. wr_last on the 3rd word -> frame_err pulse, word_cnt=0, no start; a following valid
//     6-word frame completes normally.
//  4. clear asserted with wr_valid after 4 words -> word_cnt=0, no frame_err, no start.
//  5. wr_valid held high throughout WAIT -> wr_ready=0, din unchanged, and the next word is
//     accepted only in the cycle after done.
//  6. rst_n low in mid-WAIT (counter~80) -> all outputs reset asynchronously, and the next frame
//     runs the full DONE_WAIT.
//  Bench connects the shift-register control stage downstream: its serial output must equal
//  din MSB-first, and load_sr must pulse before done.

Source files
------------

// File: rtl/sr_frame_loader_pkg.sv
// Shared definitions for the shift-register frame loader: one-hot FSM encoding and
// frame-geometry helpers.
package sr_frame_loader_pkg;

  typedef enum logic [3:0] {
    StFill  = 4'b0001,
    StStart = 4'b0010,
    StWait  = 4'b0100,
    StDone  = 4'b1000
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Valid bits carried by the final word of a frame
  function automatic int unsigned last_word_bits(input int unsigned data_w,
                                                 input int unsigned word_w);
    return data_w - (ceil_div(data_w, word_w) - 1) * word_w;
  endfunction

endpackage

// File: rtl/sr_frame_loader.sv
// Assembles a multi-word configuration frame into din, kicks the downstream shift stage with a
// start pulse, holds din for the whole shift and reports done after a fixed wait.
module sr_frame_loader
  import sr_frame_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 170,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned DONE_WAIT  = DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err,
  output logic [2:0]            word_cnt
);

  localparam int unsigned NWords    = ceil_div(DATA_WIDTH, WORD_WIDTH);
  localparam int unsigned WideWidth = NWords * WORD_WIDTH;
  localparam logic [2:0]  LastIdx   = 3'(NWords - 1);
  localparam logic [CNT_WIDTH-1:0] WaitLoad = CNT_WIDTH'(DONE_WAIT - 1);

  if (DONE_WAIT > (2 ** CNT_WIDTH) - 1) begin : g_bad_wait
    $fatal(1, "DONE_WAIT does not fit in CNT_WIDTH bits");
  end
  if (DONE_WAIT < 2) begin : g_short_wait
    $fatal(1, "DONE_WAIT must be at least 2");
  end
  if (NWords > 8) begin : g_too_many_words
    $fatal(1, "frame needs more words than word_cnt can index");
  end

  state_e                  r_state, w_state_next;
  logic [DATA_WIDTH-1:0]   r_din, w_din_next;
  logic [WideWidth-1:0]    w_din_wide;
  logic [2:0]              r_word_cnt;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_frame_err;
  logic                    w_accept, w_at_last, w_frame_end, w_err;

  assign w_accept    = wr_valid & (r_state == StFill);
  assign w_at_last   = (r_word_cnt == LastIdx);
  assign w_frame_end = w_accept & ~clear & wr_last & w_at_last;
  // wr_last must coincide exactly with the final word; either mismatch is a framing error
  assign w_err       = w_accept & ~clear & (wr_last ^ w_at_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFill:  if (w_frame_end) w_state_next = StStart;
      StStart: w_state_next = StWait;
      StWait:  if (r_cnt == '0) w_state_next = StDone;
      StDone:  w_state_next = StFill;
      default: w_state_next = StFill;
    endcase
  end

  always_comb begin
    wr_ready = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      StFill:  wr_ready = 1'b1;
      StStart: begin start = 1'b1; busy = 1'b1; end
      StWait:  busy = 1'b1;
      StDone:  begin done = 1'b1; busy = 1'b1; end
      default: wr_ready = 1'b0;
    endcase
  end

  // Padded to whole words so the final word's excess bits simply fall off the top
  always_comb begin
    w_din_wide                   = '0;
    w_din_wide[DATA_WIDTH-1:0]   = r_din;
    if (w_accept && !clear) begin
      w_din_wide[int'(r_word_cnt) * WORD_WIDTH +: WORD_WIDTH] = wr_data;
    end
    w_din_next = w_din_wide[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din       <= '0;
      r_word_cnt  <= '0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_din       <= w_din_next;
      r_frame_err <= w_err;
      if (r_state == StFill) begin
        if (clear || w_err || w_frame_end) begin
          r_word_cnt <= '0;
        end else if (w_accept) begin
          r_word_cnt <= r_word_cnt + 3'd1;
        end
      end else if (r_state == StDone) begin
        r_word_cnt <= '0;
      end
      // Loaded with the final accept so done lands DONE_WAIT cycles after start
      if (w_frame_end) begin
        r_cnt <= WaitLoad;
      end else if ((r_state == StStart) || (r_state == StWait)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign din       = r_din;
  assign word_cnt  = r_word_cnt;
  assign frame_err = r_frame_err;

endmodule
